// File: rtl/noc_host_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing the mesh host injection port between NUM_REQ requesters.
// The grant is locked from head to tail flit; a watchdog frees a grant whose owner goes quiet mid-packet.
module noc_host_inject_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int FLIT_W      = 64,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ*FLIT_W-1:0]     req_flit,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [FLIT_W-1:0]             ext_flit,
   output logic                          ext_valid,
   input  logic                          ext_ready,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          err_timeout,
   output logic                          err_proto
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   // Handshake: a flit moves on a port in every cycle where valid and ready are both 1;
   // valid is never withdrawn by the DUT while ready is low (ext_flit/ext_valid hold).
   typedef enum logic {ST_IDLE, ST_BUSY} state_e;

   state_e              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [WW-1:0]       wdog_q, wdog_d;
   logic                first_q, first_d;
   logic [FLIT_W-1:0]   ext_flit_q, ext_flit_d;
   logic                ext_valid_q, ext_valid_d;
   logic                err_timeout_q, err_timeout_d;
   logic                err_proto_q, err_proto_d;

   logic [FLIT_W-1:0]   flits [NUM_REQ];
   logic [FLIT_W-1:0]   own_flit;
   logic                own_valid, out_free, accept;
   logic [GW-1:0]       winner, cand, grant_inc;
   logic [GW:0]         cand_w;
   logic                win_found;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign flits[gi] = req_flit[gi*FLIT_W +: FLIT_W];
   end

   assign out_free  = !ext_valid_q || ext_ready;
   assign own_valid = req_valid[grant_q];
   assign own_flit  = flits[grant_q];
   assign accept    = (state_q == ST_BUSY) && own_valid && out_free;
   assign grant_inc = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // Round-robin search: first valid HEAD at or after rr_ptr, wrapping explicitly.
   always_comb begin
      winner    = '0;
      win_found = 1'b0;
      cand_w    = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_w = {1'b0, rr_ptr_q} + (GW+1)'(k);
         if (cand_w >= (GW+1)'(NUM_REQ)) cand_w = cand_w - (GW+1)'(NUM_REQ);
         cand = cand_w[GW-1:0];
         if (!win_found && req_valid[cand] && flits[cand][FLIT_W-1]) begin
            win_found = 1'b1;
            winner    = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == ST_BUSY) req_ready[grant_q] = out_free;
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      wdog_d        = wdog_q;
      first_d       = first_q;
      ext_flit_d    = ext_flit_q;
      ext_valid_d   = ext_valid_q;
      err_timeout_d = 1'b0;
      err_proto_d   = 1'b0;

      if (accept) begin
         ext_flit_d  = own_flit;
         ext_valid_d = 1'b1;
      end else if (ext_ready) begin
         ext_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            if (win_found) begin
               state_d = ST_BUSY;
               grant_d = winner;
               first_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (accept) begin
               wdog_d  = '0;
               first_d = 1'b0;
               if (own_flit[FLIT_W-2]) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = grant_inc;
               end else if (own_flit[FLIT_W-1] && !first_q) begin
                  err_proto_d = 1'b1;
               end
            end else if (own_valid) begin
               // Owner is present but held off by the mesh: not a stall of the owner.
               wdog_d = '0;
            end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
               state_d       = ST_IDLE;
               rr_ptr_d      = grant_inc;
               wdog_d        = '0;
               err_timeout_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         wdog_q        <= '0;
         first_q       <= 1'b0;
         ext_flit_q    <= '0;
         ext_valid_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_proto_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         wdog_q        <= wdog_d;
         first_q       <= first_d;
         ext_flit_q    <= ext_flit_d;
         ext_valid_q   <= ext_valid_d;
         err_timeout_q <= err_timeout_d;
         err_proto_q   <= err_proto_d;
      end
   end

   assign ext_flit    = ext_flit_q;
   assign ext_valid   = ext_valid_q;
   assign grant_id    = grant_q;
   assign busy        = (state_q == ST_BUSY);
   assign err_timeout = err_timeout_q;
   assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_noc_host_inject_arbiter.sv
// Bench for noc_host_inject_arbiter: vector table, directed multi-cycle sequences and a randomized
// run, all compared against a packet-level reference model with an expected-flit queue.
module tb_noc_host_inject_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TO = 8;

   typedef logic [W-1:0] flit_t;

   // ---------------- clock / reset ----------------
   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] req_flit;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   ext_flit;
   logic           ext_valid;
   logic           ext_ready;
   logic [1:0]     grant_id;
   logic           busy;
   logic           err_timeout;
   logic           err_proto;

   always #5 clk = ~clk;

   noc_host_inject_arbiter #(.NUM_REQ(N), .FLIT_W(W), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_flit(req_flit), .req_valid(req_valid), .req_ready(req_ready),
      .ext_flit(ext_flit), .ext_valid(ext_valid), .ext_ready(ext_ready),
      .grant_id(grant_id), .busy(busy),
      .err_timeout(err_timeout), .err_proto(err_proto)
   );

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   // ---------------- bookkeeping ----------------
   int    checks = 0;
   int    failures = 0;
   flit_t exp_q[$];
   flit_t out_log[$];
   flit_t pend [N][$];
   int    gap_cnt [N];
   int    gap_max = 0;
   int    ready_pct = 100;
   bit    manual = 1'b0;
   int    cyc = 0;
   int    et_cnt = 0;
   int    ep_cnt = 0;
   int    seq = 0;

   // reference model: owner index (-1 when nobody holds the port), rotation start, quiet-cycle count
   int    m_owner, m_rr, m_idle, m_gid;
   bit    m_first, m_ev, m_et, m_ep;
   flit_t m_ef;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic flit_t mk(input int id, input bit h, input bit t);
      seq = seq + 1;
      return {h, t, id[1:0], seq[11:0]};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_idle = 0; m_gid = 0;
      m_first = 0; m_ev = 0; m_et = 0; m_ep = 0; m_ef = '0;
      exp_q.delete();
      out_log.delete();
      for (int i = 0; i < N; i++) begin
         pend[i].delete();
         gap_cnt[i] = 0;
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive();
      if (!manual) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i].size() > 0 && gap_cnt[i] == 0) begin
               req_valid[i] = 1'b1;
               req_flit[i*W +: W] = pend[i][0];
            end else begin
               req_valid[i] = 1'b0;
               req_flit[i*W +: W] = flit_t'($urandom);
               if (gap_cnt[i] > 0) gap_cnt[i]--;
            end
         end
         ext_ready = ($urandom_range(0, 99) < ready_pct);
      end
   endtask

   // One clock: check combinational ready and the scoreboard before the edge, advance the model,
   // check registered outputs after the edge, then drive the next inputs on the falling edge.
   task automatic step();
      logic [N-1:0] mr;
      logic [N-1:0] acc_dut;
      bit           slot, found;
      int           o, c;
      flit_t        f;
      #1;
      slot = !m_ev || ext_ready;
      mr = '0;
      if (m_owner >= 0 && slot) mr[m_owner] = 1'b1;
      check("req_ready", req_ready, mr);
      acc_dut = req_valid & req_ready;
      if (ext_valid && ext_ready) begin
         if (exp_q.size() == 0) check("sb_unexpected_flit", 1, 0);
         else check("sb_flit", ext_flit, exp_q.pop_front());
         out_log.push_back(ext_flit);
      end

      m_et = 0; m_ep = 0;
      if (m_owner < 0) begin
         if (ext_ready) m_ev = 0;
         found = 0;
         for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            f = req_flit[c*W +: W];
            if (!found && req_valid[c] && f[W-1]) begin
               found = 1; m_owner = c; m_gid = c; m_idle = 0; m_first = 1;
            end
         end
      end else begin
         o = m_owner;
         f = req_flit[o*W +: W];
         if (slot && req_valid[o]) begin
            m_ev = 1; m_ef = f; exp_q.push_back(f); m_idle = 0;
            if (f[W-2]) begin
               m_owner = -1; m_rr = (o + 1) % N;
            end else if (f[W-1] && !m_first) begin
               m_ep = 1;
            end
            m_first = 0;
         end else begin
            if (ext_ready) m_ev = 0;
            if (req_valid[o]) m_idle = 0;
            else begin
               m_idle++;
               if (m_idle == TO) begin
                  m_owner = -1; m_rr = (o + 1) % N; m_et = 1; m_idle = 0;
               end
            end
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++)
         if (acc_dut[i] && pend[i].size() > 0) begin
            void'(pend[i].pop_front());
            gap_cnt[i] = $urandom_range(0, gap_max);
         end
      check("ext_valid", ext_valid, m_ev);
      check("ext_flit", ext_flit, m_ef);
      check("busy", busy, m_owner >= 0);
      check("grant_id", grant_id, m_gid);
      check("err_timeout", err_timeout, m_et);
      check("err_proto", err_proto, m_ep);
      if (err_timeout) et_cnt++;
      if (err_proto) ep_cnt++;
      @(negedge clk);
      drive();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0] vld;
      logic [N-1:0] e_ready;
      logic         e_ev;
      int           e_src;
      logic         e_busy;
      int           e_gid;
   } vec_t;

   vec_t  vt [10];
   flit_t tf [N];

   initial begin
      flit_t pkt [4];
      flit_t r3, held, fl;
      int    s0, cnt [N], r, len;

      vt[0] = '{4'b0101, 4'b0000, 0, 0, 0, 0};
      vt[1] = '{4'b0101, 4'b0001, 0, 0, 1, 0};
      vt[2] = '{4'b0100, 4'b0000, 1, 0, 0, 0};
      vt[3] = '{4'b0100, 4'b0100, 0, 0, 1, 2};
      vt[4] = '{4'b0000, 4'b0000, 1, 2, 0, 2};
      vt[5] = '{4'b0000, 4'b0000, 0, 0, 0, 2};
      vt[6] = '{4'b1111, 4'b0000, 0, 0, 0, 2};
      vt[7] = '{4'b1111, 4'b1000, 0, 0, 1, 3};
      vt[8] = '{4'b0000, 4'b0000, 1, 3, 0, 3};
      vt[9] = '{4'b0000, 4'b0000, 0, 0, 0, 3};
      for (int i = 0; i < N; i++) tf[i] = {1'b1, 1'b1, 2'(i), 12'hA00 + 12'(i)};

      // reset state
      rst_n = 1'b0; req_valid = '0; req_flit = '0; ext_ready = 1'b1;
      model_reset();
      #3;
      check("rst_ext_valid", ext_valid, 0);
      check("rst_ext_flit", ext_flit, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_errs", {err_timeout, err_proto}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // two single-flit requesters, then rotation pointer lands on 3
      manual = 1'b1;
      for (int i = 0; i < N; i++) req_flit[i*W +: W] = tf[i];
      for (int k = 0; k < 10; k++) begin
         req_valid = vt[k].vld;
         ext_ready = 1'b1;
         #1;
         check("tbl_req_ready", req_ready, vt[k].e_ready);
         check("tbl_ext_valid", ext_valid, vt[k].e_ev);
         if (vt[k].e_ev) check("tbl_ext_flit", ext_flit, tf[vt[k].e_src]);
         check("tbl_busy", busy, vt[k].e_busy);
         check("tbl_grant_id", grant_id, vt[k].e_gid);
         step();
      end
      manual = 1'b0;
      drive();

      // 4-flit packet from req1, req3 joins after its second flit: no interleave
      out_log.delete();
      for (int j = 0; j < 4; j++) pkt[j] = mk(1, j == 0, j == 3);
      for (int j = 0; j < 4; j++) pend[1].push_back(pkt[j]);
      for (int n = 0; n < 50 && pend[1].size() > 2; n++) step();
      check("wait_req1_two_flits", pend[1].size(), 2);
      r3 = mk(3, 1, 1);
      pend[3].push_back(r3);
      for (int n = 0; n < 50 && out_log.size() < 5; n++) step();
      check("wait_t3_out", out_log.size(), 5);
      for (int j = 0; j < 4; j++) check("t3_order", out_log[j], pkt[j]);
      check("t3_req3_last", out_log[4], r3);

      // output backpressure mid-packet
      for (int n = 0; n < 4; n++) step();
      out_log.delete();
      for (int j = 0; j < 4; j++) pkt[j] = mk(0, j == 0, j == 3);
      for (int j = 0; j < 4; j++) pend[0].push_back(pkt[j]);
      for (int n = 0; n < 50 && !(pend[0].size() == 2 && ext_valid); n++) step();
      check("wait_t4_mid", pend[0].size(), 2);
      ready_pct = 0;
      step();
      held = ext_flit;
      et_cnt = 0;
      for (int n = 0; n < 10; n++) begin
         #1;
         check("stall_ext_valid", ext_valid, 1);
         check("stall_ext_flit", ext_flit, held);
         check("stall_req_ready", req_ready, 0);
         step();
      end
      check("stall_no_timeout", et_cnt, 0);
      ready_pct = 100;
      for (int n = 0; n < 50 && out_log.size() < 4; n++) step();
      check("wait_t4_out", out_log.size(), 4);
      for (int j = 0; j < 4; j++) check("t4_order", out_log[j], pkt[j]);

      // HEAD without TAIL inside a packet
      ep_cnt = 0;
      pend[0].push_back(mk(0, 1, 0));
      pend[0].push_back(mk(0, 1, 0));
      pend[0].push_back(mk(0, 0, 1));
      for (int n = 0; n < 50 && pend[0].size() > 0; n++) step();
      for (int n = 0; n < 3; n++) step();
      check("proto_pulses", ep_cnt, 1);

      // watchdog: req2 sends HEAD then goes silent
      pend[2].push_back(mk(2, 1, 0));
      for (int n = 0; n < 50 && pend[2].size() > 0; n++) step();
      check("wait_req2_head", pend[2].size(), 0);
      s0 = cyc;
      et_cnt = 0;
      pend[3].push_back(mk(3, 1, 1));
      for (int n = 0; n < 40 && et_cnt == 0; n++) step();
      check("timeout_delay", cyc - s0, TO);
      check("timeout_busy_clear", busy, 0);
      for (int n = 0; n < 20 && pend[3].size() > 0; n++) step();
      check("timeout_next_grant", grant_id, 3);
      for (int n = 0; n < 12; n++) step();
      check("timeout_once", et_cnt, 1);

      // asynchronous reset in the middle of a packet
      for (int j = 0; j < 4; j++) pend[1].push_back(mk(1, j == 0, j == 3));
      for (int n = 0; n < 30 && !(ext_valid && busy); n++) step();
      check("wait_midpkt", ext_valid && busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ext_valid", ext_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_req_ready", req_ready, 0);
      check("arst_grant_id", grant_id, 0);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      drive();

      // all requesters saturated with single-flit packets: strict rotation
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 5; k++) pend[i].push_back(mk(i, 1, 1));
      for (int n = 0; n < 200 && out_log.size() < 20; n++) step();
      check("wait_rr_out", out_log.size(), 20);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < out_log.size(); k++) begin
         fl = out_log[k];
         check("rr_order", fl[13:12], k % N);
         cnt[fl[13:12]]++;
      end
      for (int i = 0; i < N; i++) check("rr_count", cnt[i], 5);

      // randomized traffic with source gaps and output backpressure
      gap_max = 2;
      ready_pct = 70;
      for (int p = 0; p < 60; p++) begin
         r = $urandom_range(0, N-1);
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++) pend[r].push_back(mk(r, j == 0, j == len-1));
      end
      for (int n = 0; n < 3000 &&
           (pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + exp_q.size() > 0); n++)
         step();
      check("rand_drained", pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() + exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
